fp_addsub_pipe: RTL and testbench

Parametrised, 3-stage pipelined IEEE-754 binary floating-point adder/subtractor with a valid/ready handshake on both sides. Successor to the combinational half-precision adder. Adds subtract mode, full subnormal/Inf/NaN handling, round-to-nearest-even, and exception flags. Sits in the datapath between operand registers and the FP result writeback; default configuration is binary16.

---
 rtl/fp_pkg.sv | 24 ++
 rtl/fp_lzc.sv | 20 ++
 rtl/fp_addsub_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point class encoding and format helpers
package fp_pkg;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_SUB,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: positive, exponent all ones, only the fraction MSB set.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] q;
        q = ((64'd1 << exp_w) - 64'd1) << man_w;
        q = q | (64'd1 << (man_w - 1));
        return q;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - parametrised leading-zero counter
module fp_lzc #(
    parameter int WIDTH = 15
) (
    input  logic [WIDTH-1:0]               data,
    output logic [$clog2(WIDTH+1)-1:0]     cnt
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    // Ascending scan: the highest set bit is the last to write the count.
    always_comb begin
        cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                cnt = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// rtl/fp_addsub_pipe.sv - 3-stage pipelined IEEE-754 adder/subtractor with valid/ready
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_y,
    output logic         out_invalid,
    output logic         out_overflow,
    output logic         out_inexact
);
    localparam int FW   = MAN_W + 4;
    localparam int SW   = MAN_W + 5;
    localparam int LZ_W = $clog2(SW + 1);
    localparam int SH_W = $clog2(FW);
    localparam logic [63:0]      QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]     QNAN      = QNAN_WIDE[W-1:0];
    localparam logic [EXP_W-1:0] EXP_ONES  = '1;
    localparam logic [EXP_W:0]   EXP_MAX   = {1'b0, EXP_ONES};

    function automatic fp_class_e classify(input logic [W-1:0] v);
        if (v[W-2:MAN_W] == '0) begin
            return (v[MAN_W-1:0] == '0) ? FP_ZERO : FP_SUB;
        end
        if (v[W-2:MAN_W] == EXP_ONES) begin
            return (v[MAN_W-1:0] == '0) ? FP_INF : FP_NAN;
        end
        return FP_NORM;
    endfunction

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    fp_class_e        cls_a, cls_b;
    logic             sign_a, sign_b, a_ge_b;
    logic [W-2:0]     mag_x, mag_y;
    logic [EXP_W-1:0] exp_x_c, exp_y_c, exp_diff;
    logic [FW-1:0]    field_x_c, field_y_c, aligned_y_c;
    logic [2*FW-1:0]  shift_wide;
    logic [SH_W-1:0]  shamt;
    logic             spec_c, spec_inv_c;
    logic [W-1:0]     spec_y_c;

    always_comb begin
        cls_a  = classify(in_a);
        cls_b  = classify(in_b);
        sign_a = in_a[W-1];
        sign_b = in_b[W-1] ^ in_sub;
        a_ge_b = in_a[W-2:0] >= in_b[W-2:0];
        mag_x  = a_ge_b ? in_a[W-2:0] : in_b[W-2:0];
        mag_y  = a_ge_b ? in_b[W-2:0] : in_a[W-2:0];

        // Subnormals and zero behave as exponent 1 with hidden bit 0.
        exp_x_c   = (mag_x[W-2:MAN_W] == '0) ? EXP_W'(1) : mag_x[W-2:MAN_W];
        exp_y_c   = (mag_y[W-2:MAN_W] == '0) ? EXP_W'(1) : mag_y[W-2:MAN_W];
        field_x_c = {mag_x[W-2:MAN_W] != '0, mag_x[MAN_W-1:0], 3'b000};
        field_y_c = {mag_y[W-2:MAN_W] != '0, mag_y[MAN_W-1:0], 3'b000};
        exp_diff  = exp_x_c - exp_y_c;
        shamt     = (32'(exp_diff) > FW - 1) ? SH_W'(FW - 1) : SH_W'(exp_diff);

        shift_wide  = {field_y_c, {FW{1'b0}}} >> shamt;
        aligned_y_c = {shift_wide[2*FW-1:FW+1], shift_wide[FW] | (|shift_wide[FW-1:0])};

        spec_c     = 1'b0;
        spec_inv_c = 1'b0;
        spec_y_c   = QNAN;
        if (cls_a == FP_NAN || cls_b == FP_NAN) begin
            spec_c     = 1'b1;
            spec_inv_c = (cls_a == FP_NAN && !in_a[MAN_W-1]) || (cls_b == FP_NAN && !in_b[MAN_W-1]);
        end else if (cls_a == FP_INF && cls_b == FP_INF && sign_a != sign_b) begin
            spec_c     = 1'b1;
            spec_inv_c = 1'b1;
        end else if (cls_a == FP_INF) begin
            spec_c   = 1'b1;
            spec_y_c = {sign_a, in_a[W-2:0]};
        end else if (cls_b == FP_INF) begin
            spec_c   = 1'b1;
            spec_y_c = {sign_b, in_b[W-2:0]};
        end
    end

    logic             s1_valid, s1_sign, s1_eff_sub, s1_zero_sign, s1_spec, s1_spec_inv;
    logic [EXP_W-1:0] s1_exp;
    logic [FW-1:0]    s1_mx, s1_my;
    logic [W-1:0]     s1_spec_y;

    logic [SW-1:0]    sum_c;
    logic [LZ_W-1:0]  lzc_c;

    assign sum_c = s1_eff_sub ? ({1'b0, s1_mx} - {1'b0, s1_my}) : ({1'b0, s1_mx} + {1'b0, s1_my});

    fp_lzc #(.WIDTH(SW)) u_lzc (
        .data (sum_c),
        .cnt  (lzc_c)
    );

    logic             s2_valid, s2_sign, s2_zero_sign, s2_spec, s2_spec_inv;
    logic [EXP_W:0]   s2_exp;
    logic [SW-1:0]    s2_sum;
    logic [LZ_W-1:0]  s2_lzc;
    logic [W-1:0]     s2_spec_y;

    logic [EXP_W:0]   n_exp, r_exp;
    logic [FW-1:0]    norm_m;
    logic [LZ_W-1:0]  lshift;
    logic [MAN_W+1:0] rnd;
    logic             round_up, res_inv, res_ovf, res_inx;
    logic [W-1:0]     res_y;

    always_comb begin
        n_exp  = s2_exp;
        norm_m = s2_sum[FW-1:0];
        lshift = '0;
        if (s2_sum[SW-1]) begin
            norm_m = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
            n_exp  = s2_exp + (EXP_W+1)'(1);
        end else begin
            lshift = s2_lzc - LZ_W'(1);
            // Stop at exponent 1; anything still unnormalised is subnormal.
            if (32'(lshift) > 32'(s2_exp) - 1) begin
                lshift = LZ_W'(s2_exp - (EXP_W+1)'(1));
            end
            norm_m = s2_sum[FW-1:0] << lshift;
            n_exp  = s2_exp - (EXP_W+1)'(lshift);
        end

        round_up = norm_m[2] & (norm_m[1] | norm_m[0] | norm_m[3]);
        rnd      = {1'b0, norm_m[FW-1:3]} + (MAN_W+2)'(round_up);
        r_exp    = n_exp;
        if (rnd[MAN_W+1]) begin
            rnd   = rnd >> 1;
            r_exp = n_exp + (EXP_W+1)'(1);
        end else if (!rnd[MAN_W]) begin
            r_exp = '0;
        end

        res_inv = 1'b0;
        res_ovf = r_exp >= EXP_MAX;
        res_inx = (|norm_m[2:0]) | res_ovf;
        res_y   = {s2_sign, r_exp[EXP_W-1:0], rnd[MAN_W-1:0]};
        if (res_ovf) begin
            res_y = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
        end
        if (s2_sum == '0) begin
            res_y   = {s2_zero_sign, {(W-1){1'b0}}};
            res_ovf = 1'b0;
            res_inx = 1'b0;
        end
        if (s2_spec) begin
            res_y   = s2_spec_y;
            res_inv = s2_spec_inv;
            res_ovf = 1'b0;
            res_inx = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s1_sign      <= 1'b0;
            s1_eff_sub   <= 1'b0;
            s1_zero_sign <= 1'b0;
            s1_spec      <= 1'b0;
            s1_spec_inv  <= 1'b0;
            s1_exp       <= '0;
            s1_mx        <= '0;
            s1_my        <= '0;
            s1_spec_y    <= '0;
            s2_valid     <= 1'b0;
            s2_sign      <= 1'b0;
            s2_zero_sign <= 1'b0;
            s2_spec      <= 1'b0;
            s2_spec_inv  <= 1'b0;
            s2_exp       <= '0;
            s2_sum       <= '0;
            s2_lzc       <= '0;
            s2_spec_y    <= '0;
            out_valid    <= 1'b0;
            out_y        <= '0;
            out_invalid  <= 1'b0;
            out_overflow <= 1'b0;
            out_inexact  <= 1'b0;
        end else if (en) begin
            s1_valid     <= in_valid;
            s1_sign      <= a_ge_b ? sign_a : sign_b;
            s1_eff_sub   <= sign_a ^ sign_b;
            s1_zero_sign <= sign_a & sign_b;
            s1_spec      <= spec_c;
            s1_spec_inv  <= spec_inv_c;
            s1_exp       <= exp_x_c;
            s1_mx        <= field_x_c;
            s1_my        <= aligned_y_c;
            s1_spec_y    <= spec_y_c;
            s2_valid     <= s1_valid;
            s2_sign      <= s1_sign;
            s2_zero_sign <= s1_zero_sign;
            s2_spec      <= s1_spec;
            s2_spec_inv  <= s1_spec_inv;
            s2_exp       <= {1'b0, s1_exp};
            s2_sum       <= sum_c;
            s2_lzc       <= lzc_c;
            s2_spec_y    <= s1_spec_y;
            out_valid    <= s2_valid;
            out_y        <= res_y;
            out_invalid  <= res_inv;
            out_overflow <= res_ovf;
            out_inexact  <= res_inx;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb/tb_fp_addsub_pipe.sv - self-checking bench for the binary16 pipelined adder
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a, in_b;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_y;
    logic        out_invalid, out_overflow, out_inexact;

    logic stall = 1'b0;
    logic bp_en = 1'b0;
    logic bp_ready = 1'b1;
    assign out_ready = stall ? 1'b0 : (bp_en ? bp_ready : 1'b1);

    fp_addsub_pipe dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_sub       (in_sub),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_invalid  (out_invalid),
        .out_overflow (out_overflow),
        .out_inexact  (out_inexact)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int check_cnt = 0;
    int results_seen = 0;
    logic [18:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        check_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e = int'(h[14:10]);
        int  f = int'(h[9:0]);
        if (e == 0) m = $itor(f) * pow2(-24);
        else m = $itor(1024 + f) * pow2(e - 25);
        return h[15] ? -m : m;
    endfunction

    // Reference: exact real sum, then round-to-nearest-even into binary16.
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic sub);
        logic sa, sb, a_nan, b_nan, a_inf, b_inf, neg, inx;
        real  v, mag, q, fr;
        int   e, n;
        sa    = a[15];
        sb    = b[15] ^ sub;
        a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 0);
        b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 0);
        a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 0);
        b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 0);
        if (a_nan || b_nan) return {16'h7E00, (a_nan && !a[9]) || (b_nan && !b[9]), 2'b00};
        if (a_inf && b_inf && sa != sb) return {16'h7E00, 3'b100};
        if (a_inf) return {sa, 15'h7C00, 3'b000};
        if (b_inf) return {sb, 15'h7C00, 3'b000};
        v = h2r({sa, a[14:0]}) + h2r({sb, b[14:0]});
        if (v == 0.0) return {sa && sb, 15'h0, 3'b000};
        neg = v < 0.0;
        mag = neg ? -v : v;
        e = 0;
        while (mag >= pow2(e + 1)) e++;
        while (mag < pow2(e)) e--;
        if (e < -14) e = -14;
        q   = mag / pow2(e - 10);
        n   = $rtoi(q);
        fr  = q - $itor(n);
        inx = fr != 0.0;
        if (fr > 0.5 || (fr == 0.5 && (n % 2) == 1)) n++;
        if (n == 2048) begin
            n = 1024;
            e++;
        end
        if (e > 15) return {neg, 15'h7C00, 3'b011};
        if (n >= 1024) return {neg, 5'(e + 15), 10'(n - 1024), 2'b00, inx};
        return {neg, 5'd0, 10'(n), 2'b00, inx};
    endfunction

    // Compare process: one scoreboard check per transferred result.
    always @(negedge clk) begin
        logic [18:0] e;
        #2;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {13'd0, out_y, out_invalid, out_overflow, out_inexact}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("result", {13'd0, out_y, out_invalid, out_overflow, out_inexact}, {13'd0, e});
                results_seen++;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] r;
        r = $urandom();
        bp_ready <= (r[1:0] != 2'b00);
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub);
        int guard = 0;
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_sub = sub;
        in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 1000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(a, b, sub));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[15] = '{
        '{16'h3C00, 16'h3C00, 1'b0, {16'h4000, 3'b000}},
        '{16'h3C00, 16'h3C00, 1'b1, {16'h0000, 3'b000}},
        '{16'h8000, 16'h8000, 1'b0, {16'h8000, 3'b000}},
        '{16'h3C00, 16'h1000, 1'b0, {16'h3C00, 3'b001}},
        '{16'h3C01, 16'h1000, 1'b0, {16'h3C02, 3'b001}},
        '{16'h7BFF, 16'h7BFF, 1'b0, {16'h7C00, 3'b011}},
        '{16'h0001, 16'h0001, 1'b0, {16'h0002, 3'b000}},
        '{16'h7C00, 16'hFC00, 1'b0, {16'h7E00, 3'b100}},
        '{16'h7D00, 16'h3C00, 1'b0, {16'h7E00, 3'b100}},
        '{16'h7C00, 16'h3C00, 1'b0, {16'h7C00, 3'b000}},
        '{16'h8000, 16'h0000, 1'b1, {16'h8000, 3'b000}},
        '{16'h4000, 16'h3C00, 1'b1, {16'h3C00, 3'b000}},
        '{16'h7E00, 16'h3C00, 1'b0, {16'h7E00, 3'b000}},
        '{16'h3C00, 16'h7C00, 1'b1, {16'hFC00, 3'b000}},
        '{16'h0400, 16'h0001, 1'b1, {16'h03FF, 3'b000}}
    };

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, seen0, stale;
        logic [18:0] held;
        logic [31:0] r1, r2;
        logic [15:0] ra, rb;

        reset = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {12'd0, out_valid, out_y, out_invalid, out_overflow, out_inexact}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) check($sformatf("model_vec%0d", i), {13'd0, model(vecs[i].a, vecs[i].b, vecs[i].sub)}, {13'd0, vecs[i].exp});

        send(16'h3C00, 16'h3C00, 1'b0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 32'd3);
        drain();

        foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].sub);
        drain();

        bp_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r1 = $urandom();
            r2 = $urandom();
            ra = r1[15:0];
            rb = r2[15:0];
            if (r2[16]) rb[14:10] = ra[14:10] ^ {3'b000, r2[18:17]};
            send(ra, rb, r2[20]);
        end
        drain();
        bp_en = 1'b0;

        @(negedge clk);
        stall = 1'b1;
        seen0 = results_seen;
        fork
            begin
                send(16'h3C00, 16'h4000, 1'b0);
                send(16'h4200, 16'h3C00, 1'b1);
                send(16'h3555, 16'h2AAA, 1'b0);
                send(16'hC000, 16'h0001, 1'b0);
            end
            begin
                lat = 0;
                while (!out_valid && lat < 20) begin
                    @(negedge clk);
                    #3;
                    lat++;
                end
                held = {out_y, out_invalid, out_overflow, out_inexact};
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    #3;
                    check("stall_hold", {13'd0, out_y, out_invalid, out_overflow, out_inexact}, {13'd0, held});
                    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                end
                @(negedge clk);
                stall = 1'b0;
            end
        join
        drain();
        check("stall_result_count", results_seen - seen0, 32'd4);

        send(16'h3C00, 16'h3800, 1'b0);
        send(16'h4400, 16'h3C00, 1'b1);
        send(16'h5000, 16'h0400, 1'b0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("reset_async_valid", {31'd0, out_valid}, 32'd0);
        check("reset_async_y", {16'd0, out_y}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        stale = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) stale = 1;
        end
        check("no_stale_after_reset", stale, 32'd0);

        send(16'h3C00, 16'h3C00, 1'b0);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
